shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width in bits (power of two, 8..64).
REQ-002 The block SHALL have parameter PIPE, default 2, meaning the number of register stages (1..log2(WIDTH)).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 type  input  6  operation code.
REQ-008 number  input  WIDTH  operand to shift.
REQ-009 movenum  input  WIDTH  shift amount, unsigned, full width.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  shifted value.
REQ-013 zero  output  1  high when result equals 0, qualified by out_valid.

Function
REQ-014 Opcodes SHALL be SLL=6'd0, SRL=6'd2, SRA=6'd3, ROL=6'd4, ROR=6'd6; any other code SHALL execute as SLL.
REQ-015 SLL/SRL SHALL zero-fill; SRA SHALL fill with number[WIDTH-1].
REQ-016 movenum >= WIDTH SHALL give 0 for SLL/SRL and WIDTH copies of number[WIDTH-1] for SRA.
REQ-017 ROL/ROR SHALL rotate by movenum mod WIDTH (low log2(WIDTH) bits only).
REQ-018 Shifting SHALL be log2(WIDTH) binary mux stages (distance 1,2,4,...), with PIPE register boundaries spread evenly, the last at the output.
REQ-019 Each register stage SHALL carry a valid bit, opcode, fill bit, overflow flag and partial data.
REQ-020 A global advance enable SHALL equal (!out_valid || out_ready); in_ready SHALL equal this enable.
REQ-021 An operation SHALL be accepted when in_valid && in_ready; with out_ready held high, result SHALL appear exactly PIPE cycles after acceptance.
REQ-022 Throughput SHALL be one operation per cycle; results SHALL leave in acceptance order, none lost or duplicated.
REQ-023 When enable is low all stages SHALL hold; result, zero and out_valid SHALL stay stable until out_ready.
REQ-024 Cycles without acceptance SHALL insert bubbles (valid=0); bubbles SHALL NOT be collapsed.
REQ-025 in_ready SHALL be independent of in_valid (no combinational path in_valid -> in_ready).
REQ-026 zero SHALL be computed from the final stage data and registered alongside result.

Reset
REQ-027 While reset is high, all stage valid bits, out_valid, result and zero SHALL be cleared to 0 on the next rising clk.
REQ-028 Operations in flight when reset is asserted SHALL be discarded; none SHALL emerge after release.
REQ-029 reset SHALL take priority over in_valid and out_ready in the same cycle.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Opcode constants and a clog2 helper SHALL live in shared package shift_pkg.
REQ-032 One sub-module shift_stage SHALL implement a single mux stage parametrised by WIDTH and shift distance, handling left, logical/arithmetic right and rotate.
REQ-033 Target size SHALL be 150-300 lines of RTL excluding package.

Verification (WIDTH=32, PIPE=2, out_ready=1 unless stated)
REQ-034 SLL number=0x00000001 movenum=31 -> result 0x80000000 two cycles later, zero=0.
REQ-035 SRA number=0x80000000 movenum=40 -> 0xFFFFFFFF; SRL same operands -> 0x00000000 with zero=1.
REQ-036 ROR number=0x000000F1 movenum=36 -> 0x1000000F; ROL number=0x80000001 movenum=1 -> 0x00000003.
REQ-037 Three back-to-back ops, out_ready low 3 cycles -> in_ready low, first result held stable, all three delivered in order after out_ready rises.
REQ-038 reset asserted with two ops in flight -> next cycle out_valid=0, result=0; no stale result after release.
REQ-039 type=6'd9 number=0x0000000F movenum=4 -> 0x000000F0 (SLL behaviour).

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared opcode constants, internal operation encoding and
//                elaboration-time helpers for the pipelined barrel shifter.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    // External 6-bit operation codes
    localparam logic [5:0] C_OPC_SLL = 6'd0;
    localparam logic [5:0] C_OPC_SRL = 6'd2;
    localparam logic [5:0] C_OPC_SRA = 6'd3;
    localparam logic [5:0] C_OPC_ROL = 6'd4;
    localparam logic [5:0] C_OPC_ROR = 6'd6;

    // Compact internal encoding carried down the pipeline
    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Unknown opcodes fall back to a logical left shift
    function automatic shift_op_e decode_op(input logic [5:0] code);
        shift_op_e op;
        case (code)
            C_OPC_SRL: op = OP_SRL;
            C_OPC_SRA: op = OP_SRA;
            C_OPC_ROL: op = OP_ROL;
            C_OPC_ROR: op = OP_ROR;
            default:   op = OP_SLL;
        endcase
        return op;
    endfunction

    // True when a register boundary follows mux stage 'stage'. Spreads
    // 'pipe' boundaries evenly over 'nstg' stages; the last stage always
    // gets one because pipe <= nstg.
    function automatic bit is_boundary(input int stage, input int pipe, input int nstg);
        return (((stage + 1) * pipe) / nstg) > ((stage * pipe) / nstg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pipe_if
//  Description : Operation/result handshake bundle for shift_pipe. The
//                operation code is named op_type because 'type' is reserved.
//  Revision    : 1.0  initial release
// ============================================================================
interface shift_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op_type;
    logic [WIDTH-1:0] number;
    logic [WIDTH-1:0] movenum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output in_valid,
        output op_type,
        output number,
        output movenum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero
    );

    // Shifter side
    modport slave (
        input  in_valid,
        input  op_type,
        input  number,
        input  movenum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_stage
//  Description : One binary mux stage of the barrel shifter. Moves the data
//                by DIST bit positions when enabled, in the direction and
//                fill mode selected by the operation.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_op_e        op_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    // Select shifted or unshifted data; SRL arrives with fill_i already 0
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SRL, OP_SRA: data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
                OP_ROL:         data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
                OP_ROR:         data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                default:        data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pipe
//  Description : Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) built from
//                log2(WIDTH) mux stages with PIPE evenly spread register
//                boundaries, the last one at the output. All stages advance
//                together under one enable, so back-pressure freezes the
//                whole pipe and bubbles keep their slots.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic       clk,
    input  logic       reset,
    shift_pipe_if.slave bus
);

    localparam int C_NSTG = clog2(WIDTH);

    // Per-stage operation record; index s is the input of mux stage s,
    // index C_NSTG is what the output register sees.
    logic             w_stg_valid [0:C_NSTG];
    shift_op_e        w_stg_op    [0:C_NSTG];
    logic             w_stg_fill  [0:C_NSTG];
    logic             w_stg_ovf   [0:C_NSTG];
    logic [WIDTH-1:0] w_stg_data  [0:C_NSTG];
    logic [C_NSTG-1:0] w_stg_amt  [0:C_NSTG-1];

    logic             w_adv;
    shift_op_e        w_in_op;
    logic             w_is_rot;
    logic [WIDTH-1:0] w_final;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    // Single advance enable depends only on output state, never on in_valid
    assign w_adv        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = w_adv;

    // Decode the request into the record entering the first mux stage
    assign w_in_op         = decode_op(bus.op_type);
    assign w_stg_valid[0]  = bus.in_valid;
    assign w_stg_op[0]     = w_in_op;
    assign w_stg_fill[0]   = (w_in_op == OP_SRA) && bus.number[WIDTH-1];
    assign w_stg_ovf[0]    = |bus.movenum[WIDTH-1:C_NSTG];
    assign w_stg_amt[0]    = bus.movenum[C_NSTG-1:0];
    assign w_stg_data[0]   = bus.number;

    genvar s;
    generate
        for (s = 0; s < C_NSTG; s = s + 1) begin : g_stage
            logic [WIDTH-1:0] w_shifted;

            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << s)
            ) u_stage (
                .data_i (w_stg_data[s]),
                .op_i   (w_stg_op[s]),
                .en_i   (w_stg_amt[s][s]),
                .fill_i (w_stg_fill[s]),
                .data_o (w_shifted)
            );

            if (s == C_NSTG - 1) begin : g_last
                // Final mux output feeds the output register directly
                assign w_stg_valid[s+1] = w_stg_valid[s];
                assign w_stg_op[s+1]    = w_stg_op[s];
                assign w_stg_fill[s+1]  = w_stg_fill[s];
                assign w_stg_ovf[s+1]   = w_stg_ovf[s];
                assign w_stg_data[s+1]  = w_shifted;
            end else if (is_boundary(s, PIPE, C_NSTG)) begin : g_reg
                logic              valid_q;
                shift_op_e         op_q;
                logic              fill_q;
                logic              ovf_q;
                logic [C_NSTG-1:0] amt_q;
                logic [WIDTH-1:0]  data_q;

                // Intermediate pipeline register, frozen while stalled
                always_ff @(posedge clk) begin
                    if (reset) begin
                        valid_q <= 1'b0;
                        op_q    <= OP_SLL;
                        fill_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        amt_q   <= '0;
                        data_q  <= '0;
                    end else if (w_adv) begin
                        valid_q <= w_stg_valid[s];
                        op_q    <= w_stg_op[s];
                        fill_q  <= w_stg_fill[s];
                        ovf_q   <= w_stg_ovf[s];
                        amt_q   <= w_stg_amt[s];
                        data_q  <= w_shifted;
                    end
                end

                assign w_stg_valid[s+1] = valid_q;
                assign w_stg_op[s+1]    = op_q;
                assign w_stg_fill[s+1]  = fill_q;
                assign w_stg_ovf[s+1]   = ovf_q;
                assign w_stg_amt[s+1]   = amt_q;
                assign w_stg_data[s+1]  = data_q;
            end else begin : g_comb
                assign w_stg_valid[s+1] = w_stg_valid[s];
                assign w_stg_op[s+1]    = w_stg_op[s];
                assign w_stg_fill[s+1]  = w_stg_fill[s];
                assign w_stg_ovf[s+1]   = w_stg_ovf[s];
                assign w_stg_amt[s+1]   = w_stg_amt[s];
                assign w_stg_data[s+1]  = w_shifted;
            end
        end
    endgenerate

    // Distances >= WIDTH saturate shifts to the fill pattern; rotates wrap
    assign w_is_rot = (w_stg_op[C_NSTG] == OP_ROL) || (w_stg_op[C_NSTG] == OP_ROR);
    assign w_final  = (w_stg_ovf[C_NSTG] && !w_is_rot) ? {WIDTH{w_stg_fill[C_NSTG]}}
                                                       : w_stg_data[C_NSTG];

    // Output register: result, zero flag and valid move together
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else if (w_adv) begin
            out_valid_q <= w_stg_valid[C_NSTG];
            result_q    <= w_final;
            zero_q      <= (w_final == '0);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_pipe
//  Description : Self-checking bench for shift_pipe (WIDTH=32, PIPE=2).
//                Expected results are queued at acceptance and compared in
//                order as the shifter delivers them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_pipe;

    localparam int WIDTH = 32;
    localparam int PIPE  = 2;

    logic clk;
    logic reset;

    shift_pipe_if #(.WIDTH(WIDTH)) bus ();

    shift_pipe #(
        .WIDTH (WIDTH),
        .PIPE  (PIPE)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // {zero, result} for every accepted operation, in acceptance order
    logic [32:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour written from the operation definitions
    function automatic logic [31:0] model(input logic [5:0] t, input logic [31:0] n,
                                          input logic [31:0] m);
        int                 sh;
        bit                 big;
        logic signed [31:0] sn;
        logic [31:0]        r;
        sh  = int'(m[4:0]);
        big = (m >= 32);
        sn  = n;
        case (t)
            6'd2:    r = big ? 32'h0 : (n >> sh);
            6'd3:    r = big ? {32{n[31]}} : 32'(sn >>> sh);
            6'd4:    r = (n << sh) | (n >> (32 - sh));
            6'd6:    r = (n >> sh) | (n << (32 - sh));
            default: r = big ? 32'h0 : (n << sh);
        endcase
        return r;
    endfunction

    // Present one operation (called just after a rising edge) and hold it
    // until accepted; returns just after the accepting edge.
    task automatic send(input logic [5:0] t, input logic [31:0] n, input logic [31:0] m,
                        input logic [31:0] exp);
        int w;
        w            = 0;
        bus.in_valid = 1'b1;
        bus.op_type  = t;
        bus.number   = n;
        bus.movenum  = m;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            w = w + 1;
            @(negedge clk);
        end
        if (bus.in_ready) exp_q.push_back({(exp == 32'h0), exp});
        else              check_eq("send_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            w = w + 1;
            @(posedge clk);
            #1;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: compare every delivered result against the queue head
    always @(negedge clk) begin : p_monitor
        logic [32:0] e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 64'(bus.result), 64'hDEAD_0000_0000);
            end else begin
                e = exp_q.pop_front();
                check_eq("result", 64'(bus.result), 64'(e[31:0]));
                check_eq("zero", 64'(bus.zero), 64'(e[32]));
            end
        end
    end

    initial begin : p_timeout
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin : p_main
        int          acc;
        int          it;
        int          stale;
        bit          took;
        int          tsel;
        logic [5:0]  rt;
        logic [31:0] rn;
        logic [31:0] rm;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_type   = 6'd0;
        bus.number    = 32'h0;
        bus.movenum   = 32'h0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_zero", 64'(bus.zero), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: SLL 1 by 31 appears exactly two cycles after acceptance
        send(6'd0, 32'h0000_0001, 32'd31, 32'h8000_0000);
        @(negedge clk);
        check_eq("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        check_eq("lat_cycle2_result", 64'(bus.result), 64'h8000_0000);
        check_eq("lat_cycle2_zero", 64'(bus.zero), 64'd0);
        @(posedge clk);
        #1;

        // Directed corner operations, back to back
        send(6'd3, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF);
        send(6'd2, 32'h8000_0000, 32'd40, 32'h0000_0000);
        send(6'd6, 32'h0000_00F1, 32'd36, 32'h1000_000F);
        send(6'd4, 32'h8000_0001, 32'd1,  32'h0000_0003);
        send(6'd9, 32'h0000_000F, 32'd4,  32'h0000_00F0);
        send(6'd3, 32'h8000_0000, 32'd4,  32'hF800_0000);
        send(6'd4, 32'h1234_5678, 32'd32, 32'h1234_5678);
        drain();

        // Back-pressure: output held stable while out_ready is low
        bus.out_ready = 1'b0;
        send(6'd0, 32'h0000_0003, 32'd4, 32'h0000_0030);
        send(6'd2, 32'h0000_00F0, 32'd4, 32'h0000_000F);
        fork
            send(6'd6, 32'h0000_0001, 32'd1, 32'h8000_0000);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check_eq("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    check_eq("stall_result", 64'(bus.result), 64'h0000_0030);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with operations in flight flushes them
        send(6'd0, 32'h0000_00AA, 32'd1, 32'h0000_0154);
        send(6'd0, 32'h0000_00BB, 32'd2, 32'h0000_02EC);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_result", 64'(bus.result), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
        stale = 0;
        repeat (6) begin
            if (bus.out_valid) stale = stale + 1;
            @(negedge clk);
        end
        check_eq("flush_no_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure and input bubbles
        acc = 0;
        it  = 0;
        while (acc < 60 && it < 2000) begin
            it = it + 1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 4) != 0) begin
                tsel = $urandom_range(0, 5);
                case (tsel)
                    0:       rt = 6'd0;
                    1:       rt = 6'd2;
                    2:       rt = 6'd3;
                    3:       rt = 6'd4;
                    4:       rt = 6'd6;
                    default: rt = 6'($urandom_range(0, 63));
                endcase
                rn = $urandom;
                rm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
                bus.op_type  = rt;
                bus.number   = rn;
                bus.movenum  = rm;
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) begin
                exp_q.push_back({(model(bus.op_type, bus.number, bus.movenum) == 32'h0),
                                 model(bus.op_type, bus.number, bus.movenum)});
                acc = acc + 1;
            end
            @(posedge clk);
            #1;
            if (took) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_eq("random_accepted", 64'(acc), 64'd60);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
